// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory loader.
// Consumes a byte stream made of a 16-bit big-endian word count N followed by
// N big-endian 32-bit words. Each word is written to instruction memory at
// BASE_ADDR + 4*k. The processor is held in reset until the load completes.
//
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN): a trailing byte equal to
// the XOR of all data bytes is required; a mismatch aborts the load.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   in_valid/in_data  byte stream source; in_ready = loader accepts a byte
//   load_req          single-cycle request to restart from DONE or ERROR
//   wr_en/wr_addr/wr_data  one-cycle instruction-memory write per word
//   cpu_reset_n       active-low processor reset, released after a good load
//   done / err        load completed / load aborted
//   words_loaded      number of words written in the current load
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic        load_req,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        cpu_reset_n,
   output logic        done,
   output logic        err,
   output logic [15:0] words_loaded
);

   localparam int unsigned CNT_W = 16;

   typedef enum logic [2:0] {
      LEN_HI = 3'd0,
      LEN_LO = 3'd1,
      DATA   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CKSUM  = 3'd3,
`endif
      DONE   = 3'd4,
      ERROR  = 3'd5
   } state_t;

   // State entered once the payload (if any) has been consumed
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t END_STATE = CKSUM;
`else
   localparam state_t END_STATE = DONE;
`endif

   state_t             state, state_d;
   logic [1:0]         byte_cnt, byte_cnt_d;
   logic [23:0]        shift, shift_d;
   logic [CNT_W-1:0]   n_words, n_words_d;
   logic [CNT_W-1:0]   len_full, words_next;
   logic               xfer;
   logic               in_ready_d, wr_en_d, cpu_reset_n_d, done_d, err_d;
   logic [31:0]        wr_addr_d, wr_data_d;
   logic [CNT_W-1:0]   words_loaded_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]         csum, csum_d;
`endif

   assign xfer = in_valid && in_ready;

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= LEN_HI;
         byte_cnt     <= 2'd0;
         shift        <= 24'd0;
         n_words      <= '0;
         in_ready     <= 1'b0;
         wr_en        <= 1'b0;
         wr_addr      <= 32'd0;
         wr_data      <= 32'd0;
         cpu_reset_n  <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum         <= 8'd0;
`endif
      end else begin
         state        <= state_d;
         byte_cnt     <= byte_cnt_d;
         shift        <= shift_d;
         n_words      <= n_words_d;
         in_ready     <= in_ready_d;
         wr_en        <= wr_en_d;
         wr_addr      <= wr_addr_d;
         wr_data      <= wr_data_d;
         cpu_reset_n  <= cpu_reset_n_d;
         done         <= done_d;
         err          <= err_d;
         words_loaded <= words_loaded_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum         <= csum_d;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d        = state;
      byte_cnt_d     = byte_cnt;
      shift_d        = shift;
      n_words_d      = n_words;
      wr_en_d        = 1'b0;
      wr_addr_d      = wr_addr;
      wr_data_d      = wr_data;
      cpu_reset_n_d  = cpu_reset_n;
      done_d         = done;
      err_d          = err;
      words_loaded_d = words_loaded;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d         = csum;
`endif
      len_full       = {n_words[15:8], in_data};
      words_next     = CNT_W'(words_loaded + 16'd1);

      case (state)
         LEN_HI: begin
            if (xfer) begin
               n_words_d = {in_data, 8'h00};
               state_d   = LEN_LO;
            end
         end
         LEN_LO: begin
            if (xfer) begin
               n_words_d  = len_full;
               byte_cnt_d = 2'd0;
               if (len_full == '0) begin
                  state_d = END_STATE;
               end else if (32'(len_full) > MAX_WORDS) begin
                  state_d = ERROR;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (xfer) begin
               byte_cnt_d = 2'(byte_cnt + 2'd1);
               shift_d    = {shift[15:0], in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d     = csum ^ in_data;
`endif
               // Fourth byte completes a word: emit the write strobe
               if (byte_cnt == 2'd3) begin
                  wr_en_d        = 1'b1;
                  wr_data_d      = {shift, in_data};
                  wr_addr_d      = BASE_ADDR + (32'(words_loaded) << 2);
                  words_loaded_d = words_next;
                  if (words_next == n_words) begin
                     state_d = END_STATE;
                  end
               end
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CKSUM: begin
            if (xfer) begin
               state_d = (in_data == csum) ? DONE : ERROR;
            end
         end
`endif
         DONE: begin
            // Release lags DONE entry by one cycle so the last write lands first
            done_d        = 1'b1;
            cpu_reset_n_d = 1'b1;
         end
         ERROR: begin
            err_d = 1'b1;
         end
         default: begin
            state_d = LEN_HI;
         end
      endcase

      // Restart request honoured only once the previous load has finished
      if (load_req && (state == DONE || state == ERROR)) begin
         state_d        = LEN_HI;
         done_d         = 1'b0;
         err_d          = 1'b0;
         cpu_reset_n_d  = 1'b0;
         words_loaded_d = '0;
         byte_cnt_d     = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_d         = 8'd0;
`endif
      end

      in_ready_d = (state_d != DONE) && (state_d != ERROR);
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader.
// Loads are described as (count, word list); the expected write sequence and
// final status are derived from the stream format rules and compared with the
// writes captured from the DUT.
module tb_imem_loader;

   localparam logic [31:0] BASE = 32'hFFFF_FFF8;
   localparam int unsigned MAXW = 4;

   typedef logic [7:0]  bq_t[$];
   typedef logic [31:0] wq_t[$];

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        load_req = 1'b0;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        cpu_reset_n;
   logic        done;
   logic        err;
   logic [15:0] words_loaded;

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] cap[$];
   int   ncyc = 0;
   int   last_xfer_neg = 0;
   int   done_rise_neg = -1;
   logic done_prev = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] ck_flip = 8'h00;
`endif

   imem_loader #(
      .BASE_ADDR (BASE),
      .MAX_WORDS (MAXW)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .load_req     (load_req),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .cpu_reset_n  (cpu_reset_n),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Observe on the falling edge: capture writes, transfer and release timing
   always @(negedge clk) begin
      ncyc++;
      if (in_valid && in_ready) last_xfer_neg = ncyc;
      if (done && !done_prev) done_rise_neg = ncyc;
      done_prev = done;
      if (wr_en) begin
         cap.push_back({wr_addr, wr_data});
         check("released_during_wr", {30'd0, done, cpu_reset_n}, 32'd0);
      end
   end

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_in_ready"},     32'(in_ready),     32'd0);
      check({pfx, "_wr_en"},        32'(wr_en),        32'd0);
      check({pfx, "_wr_addr"},      wr_addr,           32'd0);
      check({pfx, "_wr_data"},      wr_data,           32'd0);
      check({pfx, "_cpu_reset_n"},  32'(cpu_reset_n),  32'd0);
      check({pfx, "_done"},         32'(done),         32'd0);
      check({pfx, "_err"},          32'(err),          32'd0);
      check({pfx, "_words_loaded"}, 32'(words_loaded), 32'd0);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      load_req = 1'b0;
      reset_n  = 1'b0;
      #1;
      check_reset_vals("rst");
      repeat (3) @(posedge clk);
      #1;
      check("rst_hold_in_ready", 32'(in_ready), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("in_ready_before_edge", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("in_ready_after_rst", 32'(in_ready), 32'd1);
   endtask

   // mode 0: back-to-back, 1: valid every other cycle, 2: random stalls + stray load_req
   task automatic send_bytes(input bq_t q, input int mode);
      logic rdy;
      int   waited;
      for (int i = 0; i < q.size(); i++) begin
         if (mode == 1 || (mode == 2 && $urandom_range(3) == 0)) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_data  = q[i];
         load_req = (mode == 2 && i > 2 && $urandom_range(7) == 0);
         waited   = 0;
         forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            load_req = 1'b0;
            if (rdy) break;
            waited++;
            if (waited > 100) begin
               check("xfer_timeout", 32'(rdy), 32'd1);
               in_valid = 1'b0;
               return;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_end();
      int w = 0;
      while (!(done || err) && w < 40) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("end_reached", 32'(done | err), 32'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic restart();
      load_req = 1'b1;
      @(posedge clk);
      #1;
      load_req = 1'b0;
      check("rs_err",          32'(err),          32'd0);
      check("rs_done",         32'(done),         32'd0);
      check("rs_cpu_reset_n",  32'(cpu_reset_n),  32'd0);
      check("rs_words_loaded", 32'(words_loaded), 32'd0);
      check("rs_in_ready",     32'(in_ready),     32'd1);
   endtask

   // Reference: count within limit -> N writes at BASE+4k then DONE; else ERROR
   task automatic run_load(input logic [15:0] n, input wq_t words, input int mode);
      bq_t        q;
      logic [7:0] ck = 8'h00;
      bit         len_ok;
      bit         exp_done;
      int         nw;
      logic [31:0] a;
      len_ok = (32'(n) <= MAXW);
      exp_done = len_ok;
      q.push_back(n[15:8]);
      q.push_back(n[7:0]);
      if (len_ok) begin
         for (int k = 0; k < int'(n); k++) begin
            for (int b = 3; b >= 0; b--) begin
               q.push_back(8'(words[k] >> (8 * b)));
               ck = ck ^ 8'(words[k] >> (8 * b));
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         q.push_back(ck ^ ck_flip);
         if (ck_flip != 8'h00) exp_done = 1'b0;
`endif
      end
      cap.delete();
      done_rise_neg = -1;
      send_bytes(q, mode);
      wait_end();
      nw = len_ok ? int'(n) : 0;
      check("wr_count", 32'(cap.size()), 32'(nw));
      for (int k = 0; k < nw && k < cap.size(); k++) begin
         a = BASE + 32'(k) * 32'd4;
         check("wr_addr", cap[k][63:32], a);
         check("wr_data", cap[k][31:0], words[k]);
      end
      check("done",         32'(done),         32'(exp_done));
      check("err",          32'(err),          32'(!exp_done));
      check("cpu_reset_n",  32'(cpu_reset_n),  32'(exp_done));
      check("in_ready_end", 32'(in_ready),     32'd0);
      check("words_loaded", 32'(words_loaded), 32'(nw));
      if (exp_done) check("release_lat", 32'(done_rise_neg - last_xfer_neg), 32'd2);
      restart();
   endtask

   initial begin
      wq_t  w;
      bq_t  q;
      logic [15:0] n;
      int   r;

      #2;
      do_reset();

      // Two-word directed load
      w = '{32'h2008_0005, 32'h0109_0003};
      run_load(16'd2, w, 0);

      // Empty load
      w = {};
      run_load(16'd0, w, 0);

      // Count one above the limit, then exactly at the limit (addresses wrap)
      run_load(16'd5, w, 0);
      w = '{$urandom, $urandom, $urandom, $urandom};
      run_load(16'(MAXW), w, 0);

      // Same three words back-to-back and with valid toggling
      w = '{$urandom, $urandom, $urandom};
      run_load(16'd3, w, 0);
      run_load(16'd3, w, 1);

      // Large count must error
      run_load(16'hFFFF, w, 2);

      // Random loads
      for (int it = 0; it < 20; it++) begin
         r = $urandom_range(9);
         if (r < 7)       n = 16'(r % 5);
         else if (r == 7) n = 16'(MAXW + 1);
         else             n = 16'($urandom_range(6, 65535));
         w = {};
         for (int k = 0; k < 4; k++) w.push_back($urandom);
         run_load(n, w, $urandom_range(2));
      end

      // Reset in the middle of a two-word load, then a fresh one-word load
      q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
      send_bytes(q, 0);
      reset_n = 1'b0;
      #1;
      cap.delete();
      do_reset();
      repeat (3) @(posedge clk);
      #1;
      check("no_wr_after_abort", 32'(cap.size()), 32'd0);
      w = '{32'hAABB_CCDD};
      run_load(16'd1, w, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Good and corrupted checksum on the same payload
      w = '{32'h1234_5678};
      run_load(16'd1, w, 0);
      ck_flip = 8'h01;
      run_load(16'd1, w, 0);
      ck_flip = 8'h00;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
